// File: rtl/ultrasonic_trig_seq.sv
// ultrasonic_trig_seq
//   Trigger sequencer and echo supervisor for an HC-SR04 ranging path.
//   Fires a TRIG pulse of TRIG_CYCLES once every PERIOD_CYCLES while enabled.
//   Watches ECHO and classifies each measurement cycle as ok, no-echo,
//   over-range or stuck-high.
//
// Ports
//   clk         system clock (125 MHz)
//   reset       synchronous, active-high
//   enable      run continuous measurement cycles while high
//   echo        raw sensor ECHO (asynchronous)
//   trig        sensor TRIG (registered)
//   busy        high in every state except IDLE
//   meas_done   one-cycle strobe at the end of each measurement cycle
//   err_code    00 ok, 01 no echo, 10 over-range, 11 echo stuck high;
//               held until the next meas_done
//   meas_count  meas_done strobes since reset, wraps at 16 bits
module ultrasonic_trig_seq #(
    parameter int unsigned TRIG_CYCLES         = 1250,
    parameter int unsigned PERIOD_CYCLES       = 7_500_000,
    parameter int unsigned RISE_TIMEOUT_CYCLES = 250_000,
    parameter int unsigned ECHO_MAX_CYCLES     = 4_750_000,
    parameter int          CNT_W               = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic        meas_done,
    output logic [1:0]  err_code,
    output logic [15:0] meas_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_WAIT_FALL,
        ST_HOLDOFF
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NO_ECHO = 2'b01;
    localparam logic [1:0] ERR_OVER    = 2'b10;
    localparam logic [1:0] ERR_STUCK   = 2'b11;

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RISE_LAST   = CNT_W'(RISE_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST   = CNT_W'(ECHO_MAX_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + ONE;
    endfunction

    logic echo_p0;
    logic echo_s_p1;
    logic echo_s_p2;
    logic echo_rise;
    logic echo_fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             done_d;
    logic [1:0]       err_d;

    // Stage p0/p1: two-flop synchronizer; p2: delayed copy for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_p0   <= 1'b0;
            echo_s_p1 <= 1'b0;
            echo_s_p2 <= 1'b0;
        end else begin
            echo_p0   <= echo;
            echo_s_p1 <= echo_p0;
            echo_s_p2 <= echo_s_p1;
        end
    end

    assign echo_rise = echo_s_p1 & ~echo_s_p2;
    assign echo_fall = ~echo_s_p1 & echo_s_p2;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q + ONE;
        pcnt_d  = sat_inc(pcnt_q, PERIOD_LAST);
        done_d  = 1'b0;
        err_d   = err_code;
        case (state_q)
            ST_IDLE: begin
                scnt_d = '0;
                if (enable) begin
                    // The launching IDLE cycle is period cycle 0, so the
                    // trig-to-trig spacing comes out at exactly PERIOD_CYCLES.
                    pcnt_d = ONE;
                    if (echo_s_p1) begin
                        done_d  = 1'b1;
                        err_d   = ERR_STUCK;
                        state_d = ST_HOLDOFF;
                    end else begin
                        state_d = ST_TRIG;
                    end
                end
            end
            ST_TRIG: begin
                if (scnt_q == TRIG_LAST) begin
                    scnt_d  = '0;
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                // An edge arriving on the timeout cycle still counts.
                if (echo_rise) begin
                    scnt_d  = '0;
                    state_d = ST_WAIT_FALL;
                end else if (scnt_q == RISE_LAST) begin
                    done_d  = 1'b1;
                    err_d   = ERR_NO_ECHO;
                    state_d = ST_HOLDOFF;
                end
            end
            ST_WAIT_FALL: begin
                if (echo_fall) begin
                    done_d  = 1'b1;
                    err_d   = ERR_OK;
                    state_d = ST_HOLDOFF;
                end else if (scnt_q == ECHO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = ERR_OVER;
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                scnt_d = '0;
                if (pcnt_q == PERIOD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage boundary: state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            scnt_q     <= '0;
            pcnt_q     <= '0;
            trig       <= 1'b0;
            meas_done  <= 1'b0;
            err_code   <= ERR_OK;
            meas_count <= '0;
        end else begin
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            pcnt_q    <= pcnt_d;
            trig      <= (state_q == ST_TRIG);
            meas_done <= done_d;
            err_code  <= err_d;
            if (done_d) begin
                meas_count <= meas_count + 16'd1;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ultrasonic_trig_seq.sv
module tb_ultrasonic_trig_seq;

    localparam int unsigned TRIG_CYCLES         = 10;
    localparam int unsigned PERIOD_CYCLES       = 1000;
    localparam int unsigned RISE_TIMEOUT_CYCLES = 100;
    localparam int unsigned ECHO_MAX_CYCLES     = 400;
    localparam int          CNT_W               = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        echo;
    logic        trig;
    logic        busy;
    logic        meas_done;
    logic [1:0]  err_code;
    logic [15:0] meas_count;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic        en;
        logic        ec;
        int          n;
        logic        trig;
        logic        busy;
        logic        md;
        logic [1:0]  err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[$];

    ultrasonic_trig_seq #(
        .TRIG_CYCLES        (TRIG_CYCLES),
        .PERIOD_CYCLES      (PERIOD_CYCLES),
        .RISE_TIMEOUT_CYCLES(RISE_TIMEOUT_CYCLES),
        .ECHO_MAX_CYCLES    (ECHO_MAX_CYCLES),
        .CNT_W              (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .echo      (echo),
        .trig      (trig),
        .busy      (busy),
        .meas_done (meas_done),
        .err_code  (err_code),
        .meas_count(meas_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic t, input logic b, input logic m,
                             input logic [1:0] e, input logic [15:0] c);
        check({tag, ".trig"},       16'(trig),       16'(t));
        check({tag, ".busy"},       16'(busy),       16'(b));
        check({tag, ".meas_done"},  16'(meas_done),  16'(m));
        check({tag, ".err_code"},   16'(err_code),   16'(e));
        check({tag, ".meas_count"}, meas_count,      c);
    endtask

    task automatic add(input logic en, input logic ec, input int n, input logic t,
                       input logic b, input logic m, input logic [1:0] e, input logic [15:0] c);
        vec_t v;
        v.en = en; v.ec = ec; v.n = n;
        v.trig = t; v.busy = b; v.md = m; v.err = e; v.cnt = c;
        vt.push_back(v);
    endtask

    // Leaves reset released 1 ns after "edge 0" with enable/echo low.
    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        echo   = 1'b0;
        tick(3);
        reset = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_seen;

        // Edge numbers in comments count posedges after the reset release.
        //  en ec  n    trig busy md err cnt          edge
        add(1, 0, 1,    0, 1, 0, 2'd0, 16'd0);  // 1    IDLE->TRIG
        add(1, 0, 1,    1, 1, 0, 2'd0, 16'd0);  // 2    trig rises
        add(1, 0, 9,    1, 1, 0, 2'd0, 16'd0);  // 11   10th trig cycle
        add(1, 0, 1,    0, 1, 0, 2'd0, 16'd0);  // 12   trig falls
        add(1, 0, 50,   0, 1, 0, 2'd0, 16'd0);  // 62
        add(1, 1, 3,    0, 1, 0, 2'd0, 16'd0);  // 65   echo high
        add(1, 1, 197,  0, 1, 0, 2'd0, 16'd0);  // 262
        add(1, 0, 2,    0, 1, 0, 2'd0, 16'd0);  // 264  echo low
        add(1, 0, 1,    0, 1, 1, 2'd0, 16'd1);  // 265  ok
        add(1, 0, 1,    0, 1, 0, 2'd0, 16'd1);  // 266
        add(1, 0, 734,  0, 0, 0, 2'd0, 16'd1);  // 1000 IDLE
        add(1, 0, 1,    0, 1, 0, 2'd0, 16'd1);  // 1001
        add(1, 0, 1,    1, 1, 0, 2'd0, 16'd1);  // 1002 trig +1000
        add(1, 0, 9,    1, 1, 0, 2'd0, 16'd1);  // 1011
        add(1, 0, 1,    0, 1, 0, 2'd0, 16'd1);  // 1012
        add(1, 0, 98,   0, 1, 0, 2'd0, 16'd1);  // 1110 counter at 99
        add(1, 0, 1,    0, 1, 1, 2'd1, 16'd2);  // 1111 no echo
        add(1, 0, 1,    0, 1, 0, 2'd1, 16'd2);  // 1112 err held
        add(1, 0, 889,  0, 1, 0, 2'd1, 16'd2);  // 2001
        add(1, 0, 1,    1, 1, 0, 2'd1, 16'd2);  // 2002 trig +1000
        add(1, 0, 10,   0, 1, 0, 2'd1, 16'd2);  // 2012
        add(1, 1, 402,  0, 1, 0, 2'd1, 16'd2);  // 2414 echo high
        add(1, 1, 1,    0, 1, 1, 2'd2, 16'd3);  // 2415 over-range
        add(1, 1, 197,  0, 1, 0, 2'd2, 16'd3);  // 2612
        add(1, 0, 389,  0, 1, 0, 2'd2, 16'd3);  // 3001
        add(1, 0, 1,    1, 1, 0, 2'd2, 16'd3);  // 3002 trig +1000
        add(1, 0, 10,   0, 1, 0, 2'd2, 16'd3);  // 3012
        add(1, 1, 403,  0, 1, 1, 2'd2, 16'd4);  // 3415 over-range
        add(1, 1, 585,  0, 0, 0, 2'd2, 16'd4);  // 4000 IDLE, echo stuck
        add(1, 1, 1,    0, 1, 1, 2'd3, 16'd5);  // 4001 stuck high
        add(1, 1, 1,    0, 1, 0, 2'd3, 16'd5);  // 4002
        add(1, 1, 999,  0, 1, 1, 2'd3, 16'd6);  // 5001 retry at +1000

        do_reset();
        check_all("reset", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);

        for (int i = 0; i < vt.size(); i++) begin
            enable = vt[i].en;
            echo   = vt[i].ec;
            tick(vt[i].n);
            check_all($sformatf("vec%0d", i), vt[i].trig, vt[i].busy, vt[i].md,
                      vt[i].err, vt[i].cnt);
        end

        // Reset during the 5th trig-high cycle of the next measurement.
        echo = 1'b0;
        tick(1005);                                        // edge 6006
        check_all("pre_reset", 1'b1, 1'b1, 1'b0, 2'd3, 16'd6);
        reset = 1'b1;
        tick(1);                                           // edge 6007
        check_all("mid_trig_reset", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        enable = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(5);
        check_all("post_reset_idle", 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);

        // Rise reaches echo_s on the timeout cycle, then enable drops in WAIT_FALL.
        do_reset();
        enable = 1'b1;
        tick(108);
        echo = 1'b1;
        tick(3);                                           // edge 111
        check_all("tie_rise", 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        enable = 1'b0;
        echo   = 1'b0;
        tick(3);                                           // edge 114
        check_all("tie_rise_fall", 1'b0, 1'b1, 1'b1, 2'd0, 16'd1);
        tick(885);                                         // edge 999
        check("disable_holdoff.busy", 16'(busy), 16'd1);
        tick(1);                                           // edge 1000
        check_all("disable_idle", 1'b0, 1'b0, 1'b0, 2'd0, 16'd1);
        hi_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (trig || busy || meas_done) hi_seen++;
        end
        check("disable_no_retrig", 16'(hi_seen), 16'd0);

        // Fall reaches echo_s on the ECHO_MAX cycle: fall wins.
        do_reset();
        enable = 1'b1;
        tick(12);
        echo = 1'b1;
        tick(400);                                         // edge 412
        check("tie_fall_pre.meas_done", 16'(meas_done), 16'd0);
        echo = 1'b0;
        tick(2);                                           // edge 414
        check("tie_fall_edge414.meas_done", 16'(meas_done), 16'd0);
        tick(1);                                           // edge 415
        check_all("tie_fall", 1'b0, 1'b1, 1'b1, 2'd0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
